// File: rtl/tap_loader_multi.sv
// tap_loader_multi: caches an Oric .TAP image, then parses and streams each file body to RAM.
// Optional body checksum on data_sum is built when TAP_CHECKSUM_EN is defined.
module tap_loader_multi #(
   parameter int CACHE_AW = 16,
   parameter int MEM_AW   = 16,
   parameter int MAX_NAME = 16,
   parameter int SYNC_MIN = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              next_file,
   input  logic              tape_ack,
   output logic              tape_wr,
   output logic [MEM_AW-1:0] tape_addr,
   output logic [7:0]        tape_dout,
   output logic [MEM_AW-1:0] loadpoint,
   output logic [7:0]        file_type,
   output logic              tape_autorun,
   output logic              tape_complete,
   output logic              tape_error,
   output logic              more_files,
   output logic              busy,
   output logic [15:0]       data_sum
);

   localparam int PW = CACHE_AW + 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_SYNC = 3'd1;
   localparam logic [2:0] S_HDR  = 3'd2;
   localparam logic [2:0] S_NAME = 3'd3;
   localparam logic [2:0] S_DATA = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;
   localparam logic [2:0] S_ERR  = 3'd6;

   logic [7:0]        r_mem [0:(2**CACHE_AW)-1];
   logic [7:0]        r_rdata;
   logic              r_bv;
   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     r_len;
   logic              r_dl;
   logic [2:0]        r_state;
   logic [7:0]        r_cnt;
   logic [15:0]       r_end16;
   logic [15:0]       r_start16;
   logic [MEM_AW-1:0] r_addr;
   logic [MEM_AW-1:0] r_rem;
   logic [MEM_AW-1:0] r_load;
   logic [7:0]        r_type;
   logic [7:0]        r_auto;
   logic              r_arun;

   logic [CACHE_AW-1:0] w_wa;
   logic [PW-1:0]       w_wa1;
   logic [MEM_AW-1:0]   w_start;
   logic [MEM_AW-1:0]   w_end;
   logic w_dl_rise;
   logic w_dl_fall;
   logic w_have;
   logic w_scan;
   logic w_wr;
   logic w_ack;
   logic w_last;
   logic w_hold;
   logic w_fetch;
   logic w_hdr_enter;
   logic w_unused;

   assign w_wa      = ioctl_addr[CACHE_AW-1:0];
   assign w_wa1     = {1'b0, w_wa} + PW'(1);
   assign w_start   = MEM_AW'(r_start16);
   assign w_end     = MEM_AW'(r_end16);
   assign w_dl_rise = ioctl_download & ~r_dl;
   assign w_dl_fall = ~ioctl_download & r_dl;
   assign w_have    = (r_ptr < r_len);
   assign w_scan    = (r_state == S_SYNC) | (r_state == S_HDR) | (r_state == S_NAME);
   assign w_wr      = (r_state == S_DATA) & r_bv;
   assign w_ack     = w_wr & tape_ack;
   assign w_last    = w_ack & (r_rem == '0);
   assign w_hold    = w_wr & ~tape_ack;
   assign w_unused  = ^ioctl_addr[24:CACHE_AW];

   // Prefetch keeps one byte staged; in DATA it refills only once the staged byte is acked.
   assign w_fetch = w_have & (w_scan |
                    ((r_state == S_DATA) & (~r_bv | (w_ack & ~w_last))));

   assign w_hdr_enter = (r_state == S_SYNC) & r_bv & (r_rdata == 8'h24) &
                        (r_cnt >= 8'(SYNC_MIN));

   always_ff @(posedge clk) begin
      if (ioctl_download && ioctl_wr)
         r_mem[w_wa] <= ioctl_dout;
      if (w_fetch)
         r_rdata <= r_mem[r_ptr[CACHE_AW-1:0]];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dl      <= 1'b0;
         r_state   <= S_IDLE;
         r_ptr     <= '0;
         r_len     <= '0;
         r_bv      <= 1'b0;
         r_cnt     <= '0;
         r_end16   <= '0;
         r_start16 <= '0;
         r_addr    <= '0;
         r_rem     <= '0;
         r_load    <= '0;
         r_type    <= '0;
         r_auto    <= '0;
         r_arun    <= 1'b0;
      end else begin
         r_dl   <= ioctl_download;
         r_arun <= 1'b0;
         if (w_dl_rise) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_bv    <= 1'b0;
            r_len   <= ioctl_wr ? w_wa1 : '0;
            r_addr  <= '0;
            r_load  <= '0;
            r_type  <= '0;
            r_auto  <= '0;
         end else begin
            if (ioctl_download && ioctl_wr && (w_wa1 > r_len))
               r_len <= w_wa1;
            if (w_fetch) begin
               r_ptr <= r_ptr + PW'(1);
               r_bv  <= 1'b1;
            end else if (!w_hold) begin
               r_bv  <= 1'b0;
            end
            case (r_state)
               S_IDLE: begin
                  if (w_dl_fall) begin
                     r_state <= S_SYNC;
                     r_cnt   <= '0;
                  end
               end
               S_SYNC: begin
                  if (r_bv) begin
                     if (r_rdata == 8'h16) begin
                        if (r_cnt != 8'hFF)
                           r_cnt <= r_cnt + 8'd1;
                     end else if (w_hdr_enter) begin
                        r_state <= S_HDR;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= '0;
                     end
                  end else if (!w_have) begin
                     r_state <= S_ERR;
                  end
               end
               S_HDR: begin
                  if (r_bv) begin
                     r_cnt <= r_cnt + 8'd1;
                     case (r_cnt)
                        8'd2: r_type          <= r_rdata;
                        8'd3: r_auto          <= r_rdata;
                        8'd4: r_end16[15:8]   <= r_rdata;
                        8'd5: r_end16[7:0]    <= r_rdata;
                        8'd6: r_start16[15:8] <= r_rdata;
                        8'd7: r_start16[7:0]  <= r_rdata;
                        8'd8: begin
                           r_load  <= w_start;
                           r_addr  <= w_start;
                           r_rem   <= w_end - w_start;
                           r_cnt   <= '0;
                           r_state <= (w_end < w_start) ? S_ERR : S_NAME;
                        end
                        default: ;
                     endcase
                  end else if (!w_have) begin
                     r_state <= S_ERR;
                  end
               end
               S_NAME: begin
                  if (r_bv) begin
                     if ((r_rdata == 8'h00) || (r_cnt == 8'(MAX_NAME - 1)))
                        r_state <= S_DATA;
                     else
                        r_cnt <= r_cnt + 8'd1;
                  end else if (!w_have) begin
                     r_state <= S_ERR;
                  end
               end
               S_DATA: begin
                  if (w_ack) begin
                     r_addr <= r_addr + MEM_AW'(1);
                     r_rem  <= r_rem - MEM_AW'(1);
                     if (w_last) begin
                        r_arun  <= (r_auto != 8'h00);
                        r_state <= S_DONE;
                     end
                  end
               end
               S_DONE: begin
                  if (next_file && w_have) begin
                     r_state <= S_SYNC;
                     r_cnt   <= '0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef TAP_CHECKSUM_EN
   logic [15:0] r_sum;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_sum <= '0;
      else if (w_dl_rise || w_hdr_enter)
         r_sum <= '0;
      else if (w_ack)
         r_sum <= r_sum + {8'h00, r_rdata};
   end

   assign data_sum = r_sum;
`else
   assign data_sum = '0;
`endif

   assign tape_wr       = w_wr;
   assign tape_addr     = r_addr;
   assign tape_dout     = w_wr ? r_rdata : 8'h00;
   assign loadpoint     = r_load;
   assign file_type     = r_type;
   assign tape_autorun  = r_arun;
   assign tape_complete = (r_state == S_DONE);
   assign tape_error    = (r_state == S_ERR);
   assign more_files    = (r_state == S_DONE) & w_have;
   assign busy          = w_scan | (r_state == S_DATA);

endmodule
